// File: rtl/seq_mul_div_pkg.sv
// Shared encodings and helpers for the sequential multiply/divide unit.
package mul_div_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // State encoding kept as plain constants so legacy tools can trace it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_mul_div_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface seq_mul_div_if #(parameter int W = 32) ();

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] S;
  logic [W-1:0] T;
  logic         busy;
  logic         ready;
  logic         done;
  logic [W-1:0] Y_hi;
  logic [W-1:0] Y_lo;
  logic         N;
  logic         Z;
  logic         V;

  modport master (
    output start, op, S, T,
    input  busy, ready, done, Y_hi, Y_lo, N, Z, V
  );

  modport slave (
    input  start, op, S, T,
    output busy, ready, done, Y_hi, Y_lo, N, Z, V
  );

endinterface

// File: rtl/seq_mul_div_cond_neg.sv
// Combinational two's-complement negate, applied only when en is high.
module cond_neg #(parameter int N = 32) (
  input  logic [N-1:0] a,
  input  logic         en,
  output logic [N-1:0] y
);

  assign y = en ? (~a + N'(1)) : a;

endmodule

// File: rtl/seq_mul_div.sv
// Iterative radix-2 multiply/divide: magnitudes are processed over W cycles,
// signs are reapplied in a single fix-up cycle before done.
module seq_mul_div #(parameter int W = 32) (
  input logic         clk,
  input logic         reset_n,
  seq_mul_div_if.slave bus
);

  import mul_div_pkg::*;

  localparam int CW = cnt_width(W);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [1:0]     op_r;
  logic [W-1:0]   b_mag;
  logic           res_neg;
  logic           div_neg;
  logic           ovf;
  logic [2*W-1:0] acc;

  logic [W-1:0]   y_hi, y_lo;
  logic           n_flag, z_flag, v_flag;

  logic           s_neg, t_neg;
  logic [W-1:0]   s_mag, t_mag;

  assign s_neg = bus.op[0] & bus.S[W-1];
  assign t_neg = bus.op[0] & bus.T[W-1];

  cond_neg #(.N(W)) u_neg_s (.a(bus.S), .en(s_neg), .y(s_mag));
  cond_neg #(.N(W)) u_neg_t (.a(bus.T), .en(t_neg), .y(t_mag));

  // Multiply step: conditional add into the upper half, then shift right.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? b_mag : '0)};
  assign mul_next = {mul_sum, acc[W-1:1]};

  // Divide step: shift in the next dividend bit and subtract if it fits.
  logic [W:0]     rem_sh, div_diff;
  logic [2*W-1:0] div_next;
  assign rem_sh   = acc[2*W-1:W-1];
  assign div_diff = rem_sh - {1'b0, b_mag};
  assign div_next = div_diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                                : {div_diff[W-1:0], acc[W-2:0], 1'b1};

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  cond_neg #(.N(2*W)) u_neg_p (.a(acc), .en(res_neg), .y(prod_fix));
  cond_neg #(.N(W))   u_neg_q (.a(acc[W-1:0]), .en(res_neg), .y(quo_fix));
  cond_neg #(.N(W))   u_neg_r (.a(acc[2*W-1:W]), .en(div_neg), .y(rem_fix));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_r    <= '0;
      b_mag   <= '0;
      res_neg <= 1'b0;
      div_neg <= 1'b0;
      ovf     <= 1'b0;
      acc     <= '0;
      y_hi    <= '0;
      y_lo    <= '0;
      n_flag  <= 1'b0;
      z_flag  <= 1'b0;
      v_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            op_r    <= bus.op;
            b_mag   <= t_mag;
            res_neg <= s_neg ^ t_neg;
            div_neg <= s_neg;
            ovf     <= (bus.op == OP_DIV) && (bus.S == {1'b1, {(W-1){1'b0}}})
                       && (bus.T == '1);
            cnt     <= '0;
            acc     <= {{W{1'b0}}, s_mag};
            if (bus.op[1] && (bus.T == '0)) begin
              y_hi   <= bus.S;
              y_lo   <= '1;
              n_flag <= 1'b1;
              z_flag <= 1'b0;
              v_flag <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_CALC;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc <= op_r[1] ? div_next : mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W-1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (op_r[1]) begin
            y_hi   <= rem_fix;
            y_lo   <= quo_fix;
            n_flag <= quo_fix[W-1];
            z_flag <= (quo_fix == '0);
            v_flag <= ovf;
          end else begin
            y_hi   <= prod_fix[2*W-1:W];
            y_lo   <= prod_fix[W-1:0];
            n_flag <= prod_fix[2*W-1];
            z_flag <= (prod_fix == '0);
            v_flag <= 1'b0;
          end
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = (state == ST_CALC) || (state == ST_FIX);
  assign bus.ready = (state == ST_IDLE) || (state == ST_DONE);
  assign bus.done  = (state == ST_DONE);
  assign bus.Y_hi  = y_hi;
  assign bus.Y_lo  = y_lo;
  assign bus.N     = n_flag;
  assign bus.Z     = z_flag;
  assign bus.V     = v_flag;

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed and random checks of seq_mul_div against an arithmetic reference,
// with expected results queued at start and popped at done.
module tb_seq_mul_div;

  import mul_div_pkg::*;

  localparam int W = 32;

  logic clk;
  logic reset_n;

  seq_mul_div_if #(.W(W)) bus ();

  seq_mul_div #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] y_hi;
    logic [W-1:0] y_lo;
    logic         n;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_asserts;
  int   n_fail;
  int   start_cyc;
  logic saw_busy;

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] s,
                                 input logic [W-1:0] t);
    exp_t e;
    logic signed [2*W-1:0] ss, ts, ps;
    logic        [2*W-1:0] pu;
    logic signed [W-1:0]   qs, rs;
    e.v = 1'b0;
    if (!op[1]) begin
      if (op[0]) begin
        ss = $signed(s);
        ts = $signed(t);
        ps = ss * ts;
        pu = ps;
      end else begin
        pu = {{W{1'b0}}, s} * {{W{1'b0}}, t};
      end
      e.y_hi = pu[2*W-1:W];
      e.y_lo = pu[W-1:0];
      e.n    = pu[2*W-1];
      e.z    = (pu == '0);
    end else if (t == '0) begin
      e.y_hi = s;
      e.y_lo = '1;
      e.n    = 1'b1;
      e.z    = 1'b0;
      e.v    = 1'b1;
    end else if (op[0] && s == 32'h8000_0000 && t == 32'hFFFF_FFFF) begin
      e.y_hi = '0;
      e.y_lo = 32'h8000_0000;
      e.n    = 1'b1;
      e.z    = 1'b0;
      e.v    = 1'b1;
    end else begin
      if (op[0]) begin
        qs = $signed(s) / $signed(t);
        rs = $signed(s) % $signed(t);
        e.y_lo = qs;
        e.y_hi = rs;
      end else begin
        e.y_lo = s / t;
        e.y_hi = s % t;
      end
      e.n = e.y_lo[W-1];
      e.z = (e.y_lo == '0);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a request for one clock edge and queues its reference result.
  task automatic apply_stimulus(input logic [1:0] op, input logic [W-1:0] s,
                                input logic [W-1:0] t);
    bus.start = 1'b1;
    bus.op    = op;
    bus.S     = s;
    bus.T     = t;
    sb.push_back(model(op, s, t));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    start_cyc = cyc;
    saw_busy  = bus.busy;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int guard;
    guard = 0;
    while (!bus.done && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
      if (bus.busy) saw_busy = 1'b1;
    end
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_latency"}, 64'(cyc - start_cyc + 1), 64'(exp_lat));
    if (exp_lat == 1) check({tag, "_busy_never"}, 64'(saw_busy), 64'd0);
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    check({tag, "_sb_size"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_Y_hi"}, 64'(bus.Y_hi), 64'(e.y_hi));
      check({tag, "_Y_lo"}, 64'(bus.Y_lo), 64'(e.y_lo));
      check({tag, "_N"}, 64'(bus.N), 64'(e.n));
      check({tag, "_Z"}, 64'(bus.Z), 64'(e.z));
      check({tag, "_V"}, 64'(bus.V), 64'(e.v));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_ready"}, 64'(bus.ready), 64'd1);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_Y_hi"}, 64'(bus.Y_hi), 64'd0);
    check({tag, "_Y_lo"}, 64'(bus.Y_lo), 64'd0);
    check({tag, "_N"}, 64'(bus.N), 64'd0);
    check({tag, "_Z"}, 64'(bus.Z), 64'd0);
    check({tag, "_V"}, 64'(bus.V), 64'd0);
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] rs, rt;
    logic         saw_done;

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_MULTU;
    bus.S     = '0;
    bus.T     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Chain of back-to-back requests, each issued in the previous done cycle.
    apply_stimulus(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done("mult_neg", W + 2);
    check_output("mult_neg");
    apply_stimulus(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done("multu_b2b", W + 2);
    check_output("multu_b2b");
    apply_stimulus(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div_neg7", W + 2);
    check_output("div_neg7");

    apply_stimulus(OP_DIVU, 32'd7, 32'd0);
    wait_done("divu_zero", 1);
    check_output("divu_zero");
    apply_stimulus(OP_DIV, 32'd5, 32'd0);
    wait_done("div_zero", 1);
    check_output("div_zero");

    apply_stimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", W + 2);
    check_output("div_ovf");
    apply_stimulus(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("divu_big", W + 2);
    check_output("divu_big");

    // A start raised mid-calculation must be dropped without queueing.
    apply_stimulus(OP_MULT, 32'h0000_0000, 32'h1234_5678);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.S     = 32'hFFFF_FFFF;
    bus.T     = 32'hFFFF_FFFF;
    check("busy_pulse_ready", 64'(bus.ready), 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("mult_zero", W + 2);
    check_output("mult_zero");
    @(posedge clk);
    #1;
    check("ignored_start_idle", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      rs  = $urandom;
      rt  = $urandom;
      if (i < 2) rt = rt >> $urandom_range(8, 28);
      if (rop[1] && rt == '0) rt = 32'd1;
      apply_stimulus(rop, rs, rt);
      wait_done("random", W + 2);
      check_output("random");
    end

    // Reset in the middle of a calculation discards it entirely.
    apply_stimulus(OP_MULT, 32'h0000_1234, 32'h0000_5678);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("mid_reset");
    reset_n = 1'b1;
    void'(sb.pop_back());
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("mid_reset_no_done", 64'(saw_done), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mul_div.md
# seq_mul_div

Parametrised multi-cycle multiply/divide unit: the sequential successor to the single-cycle MPY/DIV path of the ALU. It executes signed and unsigned MULT/DIV with an iterative radix-2 datapath over W cycles, behind a start/done handshake. It returns a HI/LO result pair plus N/Z/V flags. It sits beside the combinational ALU and feeds the HI/LO registers of the pipeline.

## Interface
- W, default 32: operand width; results are 2W bits as Y_hi/Y_lo; W ≥ 4.
- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only when ready.
- op  in  2  bit1: 0 = multiply, 1 = divide; bit0: 0 = unsigned, 1 = signed. Encodings: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- S  in  W  multiplicand / dividend.
- T  in  W  multiplier / divisor.
- busy  out  1  high while CALC or FIX.
- ready  out  1  high in IDLE or DONE (new start is accepted).
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- Y_hi  out  W  multiply: upper product. Divide: remainder.
- Y_lo  out  W  multiply: lower product. Divide: quotient.
- N, Z, V  out  1 each  result flags.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1:
  - latch op, |S|, |T| (magnitudes when op[0]=1), the result sign and the dividend sign;
  - clear the counter.
  - Divide with T==0 goes directly to DONE. Otherwise go to CALC.
- CALC:
  - one radix-2 step per cycle; counter runs 0..W-1.
  - Multiply: shift-add into a 2W accumulator.
  - Divide: restoring shift-subtract. Quotient bits go to Y_lo, partial remainder to Y_hi.
  - After W steps, go to FIX.
- FIX:
  - Signed multiply: 2W-bit product is negated if the signs differed.
  - Signed divide: quotient is negated if the signs differed. Remainder is negated if the dividend was negative.
  - Result: truncation toward zero; remainder takes the dividend's sign.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle. Without start, go to IDLE. Outputs hold until the next accepted start.
- Flags, registered with the result:
  - Multiply: N = Y_hi[W-1]; Z = ({Y_hi,Y_lo}==0); V = 0.
  - Divide: N = Y_lo[W-1]; Z = (Y_lo==0); V = 1 on divide-by-zero or signed (−2^(W−1))/(−1), else 0.
- Divide-by-zero result: Y_lo = all ones, Y_hi = S (as latched), N = 1, Z = 0, V = 1.
- Signed overflow result: Y_lo = 2^(W−1) bit pattern, Y_hi = 0, V = 1.
- start while busy is ignored; no queueing.
- Y_hi/Y_lo/N/Z/V change only in FIX and in the divide-by-zero entry. They are not updated during CALC; the internal accumulator is separate.

## Timing
- Start sampled on edge 0:
  - busy=1 cycles 1..W+1 (CALC 1..W, FIX W+1);
  - done=1 and results valid in cycle W+2.
  - Latency is W+2 (34 for W=32).
- Divide-by-zero: done in cycle 1; busy is never asserted.
- Back-to-back: start in the DONE cycle is accepted. The next op begins CALC the following cycle.
- Reset (reset_n=0 at an edge), including mid-operation:
  - state IDLE, counter 0;
  - busy=0, ready=1, done=0;
  - Y_hi=Y_lo=0, N=0, Z=0, V=0.
  - An interrupted operation never produces done.
- Simultaneous reset and start: reset wins.

## Structure
- Package mul_div_pkg:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the state enum;
  - a function for the counter width, $clog2(W).
- One sub-module, cond_neg #(N): combinational two's-complement negate when en=1.
  - Used for operand magnitudes (W) and in FIX (2W product, W quotient/remainder).
- FSM, counter and accumulator stay in seq_mul_div.

## Test plan
All cases use W=32.
- MULT S=0xFFFFFFFF, T=0x00000002 -> done at cycle 34: Y_hi=0xFFFFFFFF, Y_lo=0xFFFFFFFE, N=1, Z=0, V=0.
- MULTU with the same operands -> Y_hi=0x00000001, Y_lo=0xFFFFFFFE, N=0. A back-to-back start in the DONE cycle gives the next done 34 cycles later.
- DIV S=0xFFFFFFF9 (−7), T=2 -> Y_lo=0xFFFFFFFD, Y_hi=0xFFFFFFFF, N=1, V=0. DIVU S=7, T=0 and DIV S=5, T=0 -> done at cycle 1, Y_lo=0xFFFFFFFF, Y_hi=S, V=1, busy never high.
- DIV S=0x80000000, T=0xFFFFFFFF -> Y_lo=0x80000000, Y_hi=0, V=1. DIVU with the same operands -> Y_lo=0, Y_hi=0x80000000, Z=1, V=0.
- MULT 0 × 0x12345678 -> Z=1, N=0. A start pulse at cycle 5 while busy -> ignored; the results match the first op only.
- Start MULT, reset_n=0 at cycle 10 -> next cycle: busy=0, ready=1, outputs all 0; no done within 40 cycles.
